halli_galli_core: RTL
=====================

# halli_galli_core

Parametrised N-player Halli Galli game engine. It sits between the keypad-scan/decode stage and the LED, seven-segment and LCD display drivers. It owns turn rotation, card generation, face-up card state, bell arbitration, judging, scoring, lockout and game-over. It replaces the fixed two-player turn, demux, card-value, correctness and push-detection chain with one sequential core.

## Interface
- PLAYERS, 2: number of players, 2..8; PW = max(1, clog2(PLAYERS))
- COLOR_W, 2: colour field width; 2^COLOR_W colours
- NUM_W, 3: number field width; 0 means no face-up card
- MAX_NUM, 5: card numbers range 1..MAX_NUM (MAX_NUM < 2^NUM_W)
- TARGET, 5: exact same-colour sum that makes a bell press correct
- SCORE_W, 8: per-player score width
- WIN_SCORE, 10: a score >= this ends the game
- PENALTY, 1: points deducted for a wrong bell
- LOCK_CYC, 4: input lockout cycles after each judgement (>= 1)
- SEED, 16'hACE1: LFSR reset value (nonzero)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- flip_pulse  in  PLAYERS  one-cycle flip request per player
- bell_pulse  in  PLAYERS  one-cycle bell press per player
- force_en  in  1  when 1, a flipped card takes force_card instead of the LFSR
- force_card  in  COLOR_W+NUM_W  {colour, number} for directed test
- turn  out  PW  index of the player allowed to flip
- top_color  out  PLAYERS*COLOR_W  face-up colour per player; player i at [i*COLOR_W +: COLOR_W]
- top_num  out  PLAYERS*NUM_W  face-up number per player; 0 = none
- score  out  PLAYERS*SCORE_W  per-player score
- bell_valid  out  1  one-cycle pulse when a judgement completes
- bell_right  out  1  judgement result; valid with bell_valid
- bell_who  out  PW  player who was judged; held until the next judgement
- game_over  out  1  game finished, sticky
- winner  out  PW  winning player; valid while game_over=1

## Operation
- Reset state: state=PLAY, turn=0, all top_* = 0, all scores = 0, cards_out=0, bell_valid/bell_right/bell_who/game_over/winner = 0, LFSR = SEED.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11. It advances every cycle, including during lockout and OVER.
- Card from LFSR: colour = lfsr[COLOR_W-1:0]; number = (lfsr[11:8] % MAX_NUM) + 1.
- Card from force_card: used as given.
- FSM states: PLAY, JUDGE, LOCK, OVER.
- PLAY, no bell asserted, flip_pulse[turn]=1:
  - the card is written to top_*[turn], replacing that player's previous face-up card;
  - cards_out increments, saturating at 2^SCORE_W-1;
  - turn becomes (turn+1) mod PLAYERS.
  - Flips from other players are ignored.
- PLAY, any bell_pulse bit asserted:
  - the lowest asserted index wins arbitration and is latched as bell_who;
  - go to JUDGE;
  - a flip in the same cycle is dropped.
- JUDGE, exactly 1 cycle. The press is right if some colour c gives a sum of top_num[i] over all i with top_color[i]==c equal to exactly TARGET. Empty slots (num=0) contribute nothing.
  - Right: score[bell_who] += cards_out, saturating. All top_* are cleared, cards_out=0, turn=bell_who.
  - Wrong: score[bell_who] -= PENALTY, floored at 0. Face-up cards, cards_out and turn are unchanged.
  - Go to LOCK.
- LOCK, LOCK_CYC cycles: all flip and bell inputs are ignored.
  - On exit, if any score >= WIN_SCORE: go to OVER, game_over=1, winner = lowest such index.
  - Otherwise return to PLAY.
- OVER: all inputs are ignored; outputs hold until reset.
- Reset asserted mid-game, including during JUDGE or LOCK, returns every register to its reset value immediately.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Flip sampled at edge k: top_*, turn and cards_out show the new values after edge k.
- Bell sampled at edge k: JUDGE runs in cycle k+1. Score, tops, bell_who and bell_right update at edge k+1, and bell_valid is high for exactly cycle k+2.
- LOCK occupies cycles k+2 .. k+1+LOCK_CYC. The first accepted input is sampled at edge k+2+LOCK_CYC.
- game_over rises at the LOCK exit edge, which is the same edge at which state leaves LOCK.
- Sum arithmetic is NUM_W+clog2(PLAYERS) bits wide; it never overflows.

## Test plan
- Reset with flips held high: after reset release, turn=0, tops=0, scores=0, game_over=0. Holding rst low masks flip_pulse.
- PLAYERS=2, force cards {1,2} by P0 then {1,3} by P1, then P1 rings -> bell_right=1, score1=2, tops cleared, turn=1. bell_valid high exactly 2 cycles after the bell.
- Force {0,2} and {1,3}, then P0 rings -> bell_right=0, score0 stays 0 (floor); a second wrong ring after a right ring worth 2 leaves score0=1.
- P0 and P1 ring in the same cycle as P0 flips -> bell_who=0, flip dropped, cards_out unchanged. A bell during LOCK_CYC=4 lockout produces no second bell_valid.
- Out-of-turn flip: P1 flips while turn=0 -> no top change. PLAYERS=3 rotation 0->1->2->0 is verified.
- WIN_SCORE=3: a right ring with cards_out=4 gives score 4 and game_over=1 with winner equal to the ringer after LOCK. Further inputs are ignored; reset clears everything.

Source files
------------

// File: rtl/halli_galli_core.sv
// halli_galli_core: N-player Halli Galli game engine.
// Turn rotation, card source, bell arbitration/judge, scoring, lockout.
module halli_galli_core #(
  parameter int PLAYERS = 2,
  parameter int COLOR_W = 2,
  parameter int NUM_W = 3,
  parameter int MAX_NUM = 5,
  parameter int TARGET = 5,
  parameter int SCORE_W = 8,
  parameter int WIN_SCORE = 10,
  parameter int PENALTY = 1,
  parameter int LOCK_CYC = 4,
  parameter logic [15:0] SEED = 16'hACE1,
  localparam int PW = (PLAYERS > 1) ? $clog2(PLAYERS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [PLAYERS-1:0]           flip_pulse,
  input  logic [PLAYERS-1:0]           bell_pulse,
  input  logic                         force_en,
  input  logic [COLOR_W+NUM_W-1:0]     force_card,
  output logic [PW-1:0]                turn,
  output logic [PLAYERS*COLOR_W-1:0]   top_color,
  output logic [PLAYERS*NUM_W-1:0]     top_num,
  output logic [PLAYERS*SCORE_W-1:0]   score,
  output logic                         bell_valid,
  output logic                         bell_right,
  output logic [PW-1:0]                bell_who,
  output logic                         game_over,
  output logic [PW-1:0]                winner
);

  localparam int SW = NUM_W + $clog2(PLAYERS);
  localparam int LW = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;
  localparam int NC = 1 << COLOR_W;

  typedef enum logic [1:0] {PLAY, JUDGE, LOCK, OVER} state_t;

  state_t                       r_state;
  state_t                       w_state_nxt;
  logic [PW-1:0]                r_turn;
  logic [PLAYERS*COLOR_W-1:0]   r_col;
  logic [PLAYERS*NUM_W-1:0]     r_num;
  logic [PLAYERS*SCORE_W-1:0]   r_score;
  logic [SCORE_W-1:0]           r_cards;
  logic [PW-1:0]                r_pend;
  logic [PW-1:0]                r_who;
  logic                         r_right;
  logic                         r_valid;
  logic                         r_over;
  logic [PW-1:0]                r_win;
  logic [15:0]                  r_lfsr;
  logic [LW-1:0]                r_lcnt;

  logic                         w_do_flip;
  logic                         w_do_bell;
  logic                         w_lock_done;
  logic [15:0]                  w_lfsr_nxt;
  logic [COLOR_W-1:0]           w_card_col;
  logic [NUM_W-1:0]             w_card_num;
  logic [NUM_W-1:0]             w_rnd_num;
  logic [PW-1:0]                w_turn_nxt;
  logic [PW-1:0]                w_bell_idx;
  logic [SW-1:0]                w_sum;
  logic                         w_right;
  logic                         w_win_any;
  logic [PW-1:0]                w_win_idx;
  logic [SCORE_W-1:0]           w_cur;
  logic [SCORE_W:0]             w_add;
  logic [SCORE_W-1:0]           w_sat;
  logic [SCORE_W-1:0]           w_sub;

  assign w_lfsr_nxt = {1'b0, r_lfsr[15:1]}
                    ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
  assign w_rnd_num  = NUM_W'((32'(r_lfsr[11:8])
                    % $unsigned(MAX_NUM)) + 32'd1);
  assign w_card_col = force_en ? force_card[COLOR_W+NUM_W-1:NUM_W]
                               : r_lfsr[COLOR_W-1:0];
  assign w_card_num = force_en ? force_card[NUM_W-1:0] : w_rnd_num;
  assign w_turn_nxt = (r_turn == PW'(PLAYERS-1)) ? '0
                    : r_turn + PW'(1);

  assign w_cur = r_score[r_pend*SCORE_W +: SCORE_W];
  assign w_add = {1'b0, w_cur} + {1'b0, r_cards};
  assign w_sat = w_add[SCORE_W] ? '1 : w_add[SCORE_W-1:0];
  assign w_sub = (32'(w_cur) >= $unsigned(PENALTY))
               ? w_cur - SCORE_W'(PENALTY) : '0;

  // lowest-index bell press wins arbitration
  always_comb begin
    w_bell_idx = '0;
    for (int i = PLAYERS-1; i >= 0; i--) begin
      if (bell_pulse[i]) w_bell_idx = PW'(i);
    end
  end

  // right when any colour's face-up numbers sum to exactly TARGET
  always_comb begin
    w_right = 1'b0;
    w_sum   = '0;
    for (int c = 0; c < NC; c++) begin
      w_sum = '0;
      for (int i = 0; i < PLAYERS; i++) begin
        if (r_col[i*COLOR_W +: COLOR_W] == COLOR_W'(c))
          w_sum = w_sum + SW'(r_num[i*NUM_W +: NUM_W]);
      end
      if (w_sum == SW'(TARGET)) w_right = 1'b1;
    end
  end

  // lowest-index player at or above the winning score
  always_comb begin
    w_win_any = 1'b0;
    w_win_idx = '0;
    for (int i = PLAYERS-1; i >= 0; i--) begin
      if (32'(r_score[i*SCORE_W +: SCORE_W]) >= $unsigned(WIN_SCORE)) begin
        w_win_any = 1'b1;
        w_win_idx = PW'(i);
      end
    end
  end

  // next-state and action strobes
  always_comb begin
    w_state_nxt = r_state;
    w_do_flip   = 1'b0;
    w_do_bell   = 1'b0;
    w_lock_done = 1'b0;
    unique case (r_state)
      PLAY: begin
        if (|bell_pulse) begin
          w_do_bell   = 1'b1;
          w_state_nxt = JUDGE;
        end else if (flip_pulse[r_turn]) begin
          w_do_flip = 1'b1;
        end
      end
      JUDGE: w_state_nxt = LOCK;
      LOCK: begin
        if (r_lcnt == LW'(LOCK_CYC-1)) begin
          w_lock_done = 1'b1;
          w_state_nxt = w_win_any ? OVER : PLAY;
        end
      end
      OVER: w_state_nxt = OVER;
      default: w_state_nxt = PLAY;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= PLAY;
    else      r_state <= w_state_nxt;
  end

  // game datapath: cards, turn, judge results, lockout, game-over
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_turn  <= '0;
      r_col   <= '0;
      r_num   <= '0;
      r_score <= '0;
      r_cards <= '0;
      r_pend  <= '0;
      r_who   <= '0;
      r_right <= 1'b0;
      r_valid <= 1'b0;
      r_over  <= 1'b0;
      r_win   <= '0;
      r_lfsr  <= SEED;
      r_lcnt  <= '0;
    end else begin
      r_lfsr  <= w_lfsr_nxt;
      r_valid <= 1'b0;
      if (w_do_bell) begin
        r_pend <= w_bell_idx;
      end
      if (w_do_flip) begin
        r_col[r_turn*COLOR_W +: COLOR_W] <= w_card_col;
        r_num[r_turn*NUM_W +: NUM_W]     <= w_card_num;
        r_turn  <= w_turn_nxt;
        r_cards <= (r_cards == '1) ? r_cards : r_cards + SCORE_W'(1);
      end
      if (r_state == JUDGE) begin
        r_valid <= 1'b1;
        r_who   <= r_pend;
        r_right <= w_right;
        r_lcnt  <= '0;
        if (w_right) begin
          r_score[r_pend*SCORE_W +: SCORE_W] <= w_sat;
          r_col   <= '0;
          r_num   <= '0;
          r_cards <= '0;
          r_turn  <= r_pend;
        end else begin
          r_score[r_pend*SCORE_W +: SCORE_W] <= w_sub;
        end
      end
      if (r_state == LOCK) begin
        r_lcnt <= r_lcnt + LW'(1);
      end
      if (w_lock_done && w_win_any) begin
        r_over <= 1'b1;
        r_win  <= w_win_idx;
      end
    end
  end

  assign turn       = r_turn;
  assign top_color  = r_col;
  assign top_num    = r_num;
  assign score      = r_score;
  assign bell_valid = r_valid;
  assign bell_right = r_right;
  assign bell_who   = r_who;
  assign game_over  = r_over;
  assign winner     = r_win;

endmodule
